// File: rtl/data_sram_ctrl.sv
// Data-side SRAM controller for the MEM stage: handshakes loads/stores
// with an addr_ok/data_ok SRAM port, extends load data, raises stalls.
// Ports:
//   clk, rst (async, active-low)
//   req_* : MEM-stage request
//   advance : WB consumes the response
//   sram_* : SRAM request/response port
//   stallreq, resp_valid, resp_rdata, misalign_err : back to the pipeline
module data_sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        advance,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;

  logic        aligned;
  logic        sz_b, sz_h;
  logic        in_idle, in_addr;
  logic        in_data, in_hold;
  logic        data_hit;
  logic [31:0] sh;
  logic [31:0] ext;

  always_comb begin
    aligned = 1'b1;
    unique case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  // rst gates the IDLE outputs so everything reads 0 while held in reset
  assign in_idle  = (state_q == IDLE) & rst;
  assign in_addr  = (state_q == ADDR);
  assign in_data  = (state_q == DATA);
  assign in_hold  = (state_q == HOLD);
  assign data_hit = in_data & sram_data_ok;

  assign sz_b = (size_q == 2'd0);
  assign sz_h = (size_q == 2'd1);

  assign sh = sram_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = '0;
    if (!we_q) begin
      unique case (1'b1)
        sz_b:
          ext = uns_q ? {24'b0, sh[7:0]}
                      : {{24{sh[7]}}, sh[7:0]};
        sz_h:
          ext = uns_q ? {16'b0, sh[15:0]}
                      : {{16{sh[15]}}, sh[15:0]};
        default:
          ext = sh;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && aligned) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sram_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (sram_data_ok) begin
          resp_d  = ext;
          state_d = advance ? IDLE : HOLD;
        end
      end
      default: begin
        if (advance) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    sram_wstrb = 4'b0000;
    sram_wdata = '0;
    if (in_addr) begin
      unique case (1'b1)
        sz_b: begin
          sram_wdata = {4{wdata_q[7:0]}};
          if (we_q) sram_wstrb = 4'b0001 << addr_q[1:0];
        end
        sz_h: begin
          sram_wdata = {2{wdata_q[15:0]}};
          if (we_q) sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          sram_wdata = wdata_q;
          if (we_q) sram_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign sram_req  = in_addr;
  assign sram_wr   = in_addr & we_q;
  assign sram_size = in_addr ? size_q : 2'd0;
  assign sram_addr = in_addr ? addr_q : '0;

  assign misalign_err = in_idle & req_valid & ~aligned;
  assign stallreq     = (in_idle & req_valid & aligned)
                      | in_addr
                      | (in_data & ~sram_data_ok);
  assign resp_valid   = data_hit | in_hold;
  assign resp_rdata   = data_hit ? ext
                      : (in_hold ? resp_q : '0);

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: zero-wait loads/stores, misalign,
// slow SRAM with WB hold, and reset in the middle of a transaction.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        advance;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  logic        stallreq, resp_valid, misalign_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  data_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .advance(advance),
    .sram_req(sram_req), .sram_wr(sram_wr),
    .sram_size(sram_size), .sram_addr(sram_addr),
    .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
    .sram_rdata(sram_rdata),
    .stallreq(stallreq), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transaction: request, ADDR with addr_ok, DATA with data_ok.
  task automatic txn(input string t,
                     input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input logic [3:0] e_strb,
                     input logic [31:0] e_wd,
                     input logic [31:0] e_resp);
    req_valid = 1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    #1;
    chk({t, "_req_stall"}, 32'(stallreq), 32'd1);
    chk({t, "_req_sreq"}, 32'(sram_req), 32'd0);
    step;
    req_valid = 0; sram_addr_ok = 1;
    #1;
    chk({t, "_sreq"}, 32'(sram_req), 32'd1);
    chk({t, "_swr"}, 32'(sram_wr), 32'(we));
    chk({t, "_ssize"}, 32'(sram_size), 32'(sz));
    chk({t, "_saddr"}, sram_addr, a);
    chk({t, "_wstrb"}, 32'(sram_wstrb), 32'(e_strb));
    chk({t, "_wdata"}, sram_wdata, e_wd);
    chk({t, "_addr_stall"}, 32'(stallreq), 32'd1);
    step;
    sram_addr_ok = 0; sram_data_ok = 1;
    sram_rdata = rd; advance = 1;
    #1;
    chk({t, "_data_sreq"}, 32'(sram_req), 32'd0);
    chk({t, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({t, "_rdata"}, resp_rdata, e_resp);
    chk({t, "_data_stall"}, 32'(stallreq), 32'd0);
    step;
    sram_data_ok = 0;
    #1;
    chk({t, "_idle_rvalid"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 0; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    advance = 0; sram_addr_ok = 0; sram_data_ok = 0;
    sram_rdata = 0;
    #3;
    chk("rst_sreq", 32'(sram_req), 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    #4 rst = 1;
    step;

    txn("wload", 0, 2'd2, 0, 32'h100, 32'h0, 32'h8000_00FF,
        4'b0000, 32'h0, 32'h8000_00FF);
    txn("sbyte", 0, 2'd0, 0, 32'h103, 32'h0, 32'h80AA_BBCC,
        4'b0000, 32'h0, 32'hFFFF_FF80);
    txn("ubyte", 0, 2'd0, 1, 32'h103, 32'h0, 32'h80AA_BBCC,
        4'b0000, 32'h0, 32'h0000_0080);
    txn("shalf", 0, 2'd1, 0, 32'h002, 32'h0, 32'h8001_7FFF,
        4'b0000, 32'h0, 32'hFFFF_8001);
    txn("hstore", 1, 2'd1, 0, 32'h202, 32'h0000_1234, 32'hDEAD_BEEF,
        4'b1100, 32'h1234_1234, 32'h0);
    txn("bstore", 1, 2'd0, 0, 32'h101, 32'h0000_00AB, 32'h0,
        4'b0010, 32'hABAB_ABAB, 32'h0);
    txn("w3load", 0, 2'd3, 0, 32'h10C, 32'h0, 32'h1357_9BDF,
        4'b0000, 32'h0, 32'h1357_9BDF);

    // misaligned word load
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h101;
    #1;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_stall", 32'(stallreq), 32'd0);
    chk("mis_sreq", 32'(sram_req), 32'd0);
    step;
    req_valid = 0;
    #1;
    chk("mis_err_off", 32'(misalign_err), 32'd0);
    chk("mis_sreq2", 32'(sram_req), 32'd0);
    chk("mis_stall2", 32'(stallreq), 32'd0);

    // slow SRAM with WB hold
    req_valid = 1; req_we = 0; req_size = 2'd2;
    req_unsigned = 0; req_addr = 32'h40;
    step;
    req_valid = 1; req_addr = 32'h41;
    sram_data_ok = 1;
    #1;
    chk("slow_a0_sreq", 32'(sram_req), 32'd1);
    chk("slow_a0_mis", 32'(misalign_err), 32'd0);
    chk("slow_a0_rv", 32'(resp_valid), 32'd0);
    step;
    req_valid = 0; sram_data_ok = 0;
    #1;
    chk("slow_a1_stall", 32'(stallreq), 32'd1);
    step;
    sram_addr_ok = 1;
    #1;
    chk("slow_a2_sreq", 32'(sram_req), 32'd1);
    chk("slow_a2_addr", sram_addr, 32'h40);
    step;
    sram_addr_ok = 0;
    #1;
    chk("slow_d0_sreq", 32'(sram_req), 32'd0);
    chk("slow_d0_stall", 32'(stallreq), 32'd1);
    chk("slow_d0_rv", 32'(resp_valid), 32'd0);
    step;
    #1;
    chk("slow_d1_stall", 32'(stallreq), 32'd1);
    sram_data_ok = 1; sram_rdata = 32'h1122_3344; advance = 0;
    #1;
    chk("slow_d2_rv", 32'(resp_valid), 32'd1);
    chk("slow_d2_rd", resp_rdata, 32'h1122_3344);
    chk("slow_d2_stall", 32'(stallreq), 32'd0);
    step;
    sram_rdata = 32'hFFFF_0000;
    #1;
    chk("slow_h0_rv", 32'(resp_valid), 32'd1);
    chk("slow_h0_rd", resp_rdata, 32'h1122_3344);
    chk("slow_h0_stall", 32'(stallreq), 32'd0);
    step;
    sram_data_ok = 0; advance = 1;
    #1;
    chk("slow_h1_rv", 32'(resp_valid), 32'd1);
    chk("slow_h1_rd", resp_rdata, 32'h1122_3344);
    step;
    #1;
    chk("slow_idle_rv", 32'(resp_valid), 32'd0);
    chk("slow_idle_stall", 32'(stallreq), 32'd0);

    // reset while in DATA
    req_valid = 1; req_size = 2'd2; req_addr = 32'h80;
    step;
    req_valid = 0; sram_addr_ok = 1;
    step;
    sram_addr_ok = 0;
    #1;
    chk("rd_data_stall", 32'(stallreq), 32'd1);
    rst = 0;
    #1;
    chk("rd_sreq", 32'(sram_req), 32'd0);
    chk("rd_stall", 32'(stallreq), 32'd0);
    chk("rd_rv", 32'(resp_valid), 32'd0);
    sram_data_ok = 1; sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("rd_rv_dok", 32'(resp_valid), 32'd0);
    step;
    rst = 1;
    step;
    #1;
    chk("rd_late_rv", 32'(resp_valid), 32'd0);
    chk("rd_late_stall", 32'(stallreq), 32'd0);
    chk("rd_late_sreq", 32'(sram_req), 32'd0);
    sram_data_ok = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
